xbee_api_rx: RTL and testbench

- Fabric-side receiver for xBee API frames arriving on a UART RX pin: the far end of the MSS-driven xBee transmit path.
- Oversamples and deserializes UART bytes, then parses API frames: delimiter 0x7E, 16-bit length, frame data, checksum.
- Buffers the frame data until the checksum passes, then streams it out on a valid/ready byte interface.
- Feeds the fabric command decoder on the receiving board.

---
 rtl/xbee_pkg.sv | 29 ++
 rtl/xbee_api_rx_if.sv | 11 +
 rtl/xbee_api_rx_uart_rx_byte.sv | 97 +++++++++
 rtl/xbee_api_rx.sv | 174 +++++++++++++++++
 tb/tb_xbee_api_rx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xbee_pkg.sv
// Shared constants, error codes and parser state encoding for the xBee API receive path.
package xbee_pkg;

  localparam logic [7:0] API_DELIM = 8'h7E;
  localparam logic [7:0] API_ESC   = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  localparam logic [1:0] ERR_FRAMING = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_MSB,
    ST_LEN_LSB,
    ST_DATA,
    ST_CSUM,
    ST_OUTPUT
  } parser_state_t;

  // Frame data plus checksum byte must sum to 0xFF modulo 256.
  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
    logic [7:0] total;
    total = sum + csum;
    return total == 8'hFF;
  endfunction

endpackage

// File: rtl/xbee_api_rx_if.sv
// Frame-data streaming interface: valid/ready byte stream with last marker and frame length.
interface xbee_api_rx_if;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic [15:0] FRAME_LEN;

  modport master (output OUT_DATA, OUT_VALID, OUT_LAST, FRAME_LEN, input OUT_READY);
  modport slave  (input OUT_DATA, OUT_VALID, OUT_LAST, FRAME_LEN, output OUT_READY);
endinterface

// File: rtl/xbee_api_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, 16x oversampling tick, mid-bit sampling,
// one-cycle byte strobe or framing-error strobe.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ_HZ = 40_000_000,
  parameter int unsigned BAUD        = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int unsigned TICK_RAW = (CLK_FREQ_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned TICK_DIV = (TICK_RAW == 0) ? 1 : TICK_RAW;
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        state_q, state_d;
  logic             rxd_meta, rxd_s, rxd_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tick, mid, stb_d, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  // Tick phase restarts at each detected start edge; the 8th tick of every bit is mid-bit.
  assign tick = (state_q != RX_IDLE) && (div_cnt == DIV_W'(TICK_DIV - 1));
  assign mid  = tick && (samp_cnt == 4'd7);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE:  if (rxd_prev && !rxd_s) state_d = RX_START;
      RX_START: if (mid) state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (mid && bit_cnt == 3'd7) state_d = RX_STOP;
      RX_STOP: begin
        if (mid) begin
          state_d = RX_IDLE;
          stb_d   = rxd_s;
          ferr_d  = !rxd_s;
        end
      end
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_data <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= stb_d;
      frame_err <= ferr_d;
      if (state_q == RX_IDLE) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) samp_cnt <= samp_cnt + 4'd1;
        if (mid && state_q == RX_DATA) begin
          shreg   <= {rxd_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (stb_d) byte_data <= shreg;
    end
  end

endmodule

// File: rtl/xbee_api_rx.sv
// xBee API frame receiver: UART bytes -> delimiter/length/data/checksum parser -> buffered stream.
// Optional API mode 2 escaping is enabled by defining XBEE_API_ESCAPE_EN.
module xbee_api_rx
  import xbee_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 40_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned MAX_PAYLOAD = 32
) (
  input  logic                FAB_CLK,
  input  logic                FAB_RESET,
  input  logic                UART_RXD,
  xbee_api_rx_if.master       out_if,
  output logic                ERR_STB,
  output logic [1:0]          ERR_CODE
);

  localparam int unsigned IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  parser_state_t state_q, state_d;
  logic [7:0]    rx_byte, b;
  logic          rx_stb, rx_ferr, data_stb, abort;
  logic [15:0]   len_q, len_new, wr_idx, rd_idx, frame_len_q;
  logic [7:0]    sum_q, out_data_q;
  logic          out_valid_q, out_last_q, err_d;
  logic [1:0]    code_d;
  logic [7:0]    mem [MAX_PAYLOAD];

  uart_rx_byte #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) u_rx (
    .clk      (FAB_CLK),
    .rst      (FAB_RESET),
    .rxd      (UART_RXD),
    .byte_data(rx_byte),
    .byte_stb (rx_stb),
    .frame_err(rx_ferr)
  );

`ifdef XBEE_API_ESCAPE_EN
  logic esc_q, in_frame, esc_consume;
  assign in_frame    = state_q inside {ST_LEN_MSB, ST_LEN_LSB, ST_DATA, ST_CSUM};
  assign b           = esc_q ? (rx_byte ^ ESC_XOR) : rx_byte;
  assign abort       = rx_stb && in_frame && !esc_q && (rx_byte == API_DELIM);
  assign esc_consume = rx_stb && in_frame && !esc_q && (rx_byte == API_ESC);
  assign data_stb    = rx_stb && !abort && !esc_consume;

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET || abort || state_q == ST_IDLE) esc_q <= 1'b0;
    else if (esc_consume)                         esc_q <= 1'b1;
    else if (rx_stb)                              esc_q <= 1'b0;
  end
`else
  assign b        = rx_byte;
  assign abort    = 1'b0;
  assign data_stb = rx_stb;
`endif

  assign len_new = {len_q[15:8], b};

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    code_d  = ERR_FRAMING;
    if (rx_ferr) begin
      // A line error never tears down a stream already handed to the consumer.
      err_d = 1'b1;
      if (state_q != ST_OUTPUT) state_d = ST_IDLE;
    end else if (abort) begin
      state_d = ST_LEN_MSB;
    end else if (data_stb) begin
      case (state_q)
        ST_IDLE:    if (b == API_DELIM) state_d = ST_LEN_MSB;
        ST_LEN_MSB: state_d = ST_LEN_LSB;
        ST_LEN_LSB: begin
          if (len_new == 16'd0 || len_new > 16'(MAX_PAYLOAD)) begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA:    if (wr_idx == len_q - 16'd1) state_d = ST_CSUM;
        ST_CSUM: begin
          if (csum_ok(sum_q, b)) begin
            state_d = ST_OUTPUT;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = ST_IDLE;
          end
        end
        ST_OUTPUT: begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
    if (state_q == ST_OUTPUT && out_valid_q && out_if.OUT_READY && out_last_q)
      state_d = ST_IDLE;
  end

  always_ff @(posedge FAB_CLK) begin
    if (data_stb && state_q == ST_DATA) mem[wr_idx[IDX_W-1:0]] <= b;
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      len_q       <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      sum_q       <= '0;
      frame_len_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ERR_STB     <= 1'b0;
      ERR_CODE    <= '0;
    end else begin
      ERR_STB  <= err_d;
      ERR_CODE <= err_d ? code_d : 2'd0;
      if (data_stb && !rx_ferr && !abort) begin
        case (state_q)
          ST_LEN_MSB: len_q[15:8] <= b;
          ST_LEN_LSB: begin
            len_q[7:0] <= b;
            wr_idx     <= '0;
            sum_q      <= '0;
          end
          ST_DATA: begin
            wr_idx <= wr_idx + 16'd1;
            sum_q  <= sum_q + b;
          end
          ST_CSUM: begin
            if (state_d == ST_OUTPUT) begin
              frame_len_q <= len_q;
              rd_idx      <= '0;
            end
          end
          default: ;
        endcase
      end
      // rd_idx points at the next buffer entry to load into the output register.
      if (state_q == ST_OUTPUT) begin
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= mem[rd_idx[IDX_W-1:0]];
          out_last_q  <= (rd_idx == len_q - 16'd1);
          rd_idx      <= rd_idx + 16'd1;
        end else if (out_if.OUT_READY) begin
          if (out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else begin
            out_data_q <= mem[rd_idx[IDX_W-1:0]];
            out_last_q <= (rd_idx == len_q - 16'd1);
            rd_idx     <= rd_idx + 16'd1;
          end
        end
      end
    end
  end

  assign out_if.OUT_DATA  = out_data_q;
  assign out_if.OUT_VALID = out_valid_q;
  assign out_if.OUT_LAST  = out_last_q;
  assign out_if.FRAME_LEN = frame_len_q;

endmodule

// File: tb/tb_xbee_api_rx.sv
// Directed bench for xbee_api_rx: serial frames in, streamed bytes and error pulses checked.
module tb_xbee_api_rx;
  import xbee_pkg::*;

  localparam int unsigned CLK_HZ   = 3_200_000;
  localparam int unsigned BAUD_R   = 100_000;
  localparam int unsigned MAXP     = 32;
  localparam int unsigned BIT_CLKS = 32;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       err_stb;
  logic [1:0] err_code;

  xbee_api_rx_if bus();

  xbee_api_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .MAX_PAYLOAD(MAXP)) dut (
    .FAB_CLK  (clk),
    .FAB_RESET(rst),
    .UART_RXD (rxd),
    .out_if   (bus.master),
    .ERR_STB  (err_stb),
    .ERR_CODE (err_code)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [8:0]  xq[$];
  int unsigned xcyc[$];
  logic [1:0]  eq[$];
  int unsigned vrise[$];
  int unsigned last_rx_cyc = 0;
  int unsigned rx_cnt = 0;
  logic        prev_valid = 1'b0;
  bq_t         fr;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #1;
    if (bus.OUT_VALID && bus.OUT_READY) begin
      xq.push_back({bus.OUT_LAST, bus.OUT_DATA});
      xcyc.push_back(cyc);
    end
    if (err_stb) eq.push_back(err_code);
    if (bus.OUT_VALID && !prev_valid) vrise.push_back(cyc);
    prev_valid = bus.OUT_VALID;
    if (dut.rx_stb) begin
      rx_cnt++;
      last_rx_cyc = cyc;
    end
  end

  task automatic clr();
    xq.delete(); xcyc.delete(); eq.delete(); vrise.delete();
    rx_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop_bit = 1'b1);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send_byte(f[i]);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.OUT_READY = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.OUT_VALID); end
    checks++; if (bus.OUT_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.OUT_DATA); end
    checks++; if (bus.OUT_LAST !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.OUT_LAST); end
    checks++; if (bus.FRAME_LEN !== 16'h0000) begin errors++; $display("FAIL reset_len: got %h want 0000", bus.FRAME_LEN); end
    checks++; if (err_stb !== 1'b0) begin errors++; $display("FAIL reset_err_stb: got %b want 0", err_stb); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [8:0] exp [3];
    logic [8:0] got;
    exp = '{9'h041, 9'h042, 9'h143};
    clr();
    fr = '{8'h7E, 8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h39};
    send_frame(fr);
    checks++; if (xq.size() !== 3) begin errors++; $display("FAIL good_count: got %0d want 3", xq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < xq.size()) ? xq[i] : 9'h1FF;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL good_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    checks++;
    if (xcyc.size() != 3 || xcyc[2] - xcyc[0] !== 2) begin
      errors++; $display("FAIL good_consecutive: got %0d transfers not on consecutive cycles", xcyc.size());
    end
    checks++;
    if (vrise.size() != 1 || vrise[0] - last_rx_cyc !== 2) begin
      errors++; $display("FAIL good_latency: got %0d rises, delay %0d want 2", vrise.size(), (vrise.size() > 0) ? vrise[0] - last_rx_cyc : 0);
    end
    checks++; if (bus.FRAME_LEN !== 16'd3) begin errors++; $display("FAIL good_frame_len: got %0d want 3", bus.FRAME_LEN); end
    checks++; if (eq.size() !== 0) begin errors++; $display("FAIL good_no_err: got %0d pulses want 0", eq.size()); end
  endtask

  task automatic test_bad_csum();
    logic [8:0] exp [3];
    logic [8:0] got;
    exp = '{9'h041, 9'h042, 9'h143};
    clr();
    fr = '{8'h7E, 8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h3A};
    send_frame(fr);
    checks++; if (eq.size() !== 1) begin errors++; $display("FAIL csum_err_count: got %0d want 1", eq.size()); end
    checks++; if (eq.size() > 0 && eq[0] !== ERR_CSUM) begin errors++; $display("FAIL csum_err_code: got %0d want 2", eq[0]); end
    checks++; if (vrise.size() !== 0) begin errors++; $display("FAIL csum_no_valid: got %0d valid rises want 0", vrise.size()); end
    clr();
    fr = '{8'h7E, 8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h39};
    send_frame(fr);
    checks++; if (xq.size() !== 3) begin errors++; $display("FAIL csum_recover_count: got %0d want 3", xq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < xq.size()) ? xq[i] : 9'h1FF;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL csum_recover_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_bad_length();
    clr();
    fr = '{8'h7E, 8'h00, 8'h00};
    send_frame(fr);
    fr = '{8'h7E, 8'h00, 8'h21};
    send_frame(fr);
    checks++; if (eq.size() !== 2) begin errors++; $display("FAIL len_err_count: got %0d want 2", eq.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= eq.size() || eq[i] !== ERR_BAD_LEN) begin errors++; $display("FAIL len_err_code%0d: got %0d want 1", i, (i < eq.size()) ? eq[i] : 2'd0); end
    end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL len_idle: got state %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_framing_and_glitch();
    clr();
    fr = '{8'h7E, 8'h00, 8'h03, 8'h41};
    foreach (fr[i]) send_byte(fr[i]);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43);
    send_byte(8'h39);
    repeat (60) @(negedge clk);
    checks++; if (eq.size() !== 1) begin errors++; $display("FAIL frame_err_count: got %0d want 1", eq.size()); end
    checks++; if (eq.size() > 0 && eq[0] !== ERR_FRAMING) begin errors++; $display("FAIL frame_err_code: got %0d want 0", eq[0]); end
    checks++; if (xq.size() !== 0) begin errors++; $display("FAIL frame_discard: got %0d bytes want 0", xq.size()); end
    clr();
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL glitch_no_byte: got %0d strobes want 0", rx_cnt); end
    checks++; if (eq.size() !== 0) begin errors++; $display("FAIL glitch_no_err: got %0d pulses want 0", eq.size()); end
  endtask

  task automatic test_backpressure_overrun();
    logic [8:0] exp [3];
    logic [8:0] got;
    int         bad;
    exp = '{9'h041, 9'h042, 9'h143};
    clr();
    bus.OUT_READY = 1'b0;
    fr = '{8'h7E, 8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h39};
    send_frame(fr);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus.OUT_VALID === 1'b1 && bus.OUT_DATA === 8'h41 && bus.OUT_LAST === 1'b0)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    send_byte(8'h55);
    repeat (10) @(negedge clk);
    checks++; if (eq.size() !== 1 || eq[0] !== ERR_OVERRUN) begin errors++; $display("FAIL overrun_err: got %0d pulses want one code 3", eq.size()); end
    checks++; if (bus.OUT_DATA !== 8'h41 || bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL overrun_hold: got %h/%b want 41/1", bus.OUT_DATA, bus.OUT_VALID); end
    bus.OUT_READY = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (xq.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", xq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < xq.size()) ? xq[i] : 9'h1FF;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    clr();
    fr = '{8'h7E, 8'h00, 8'h03, 8'h41};
    foreach (fr[i]) send_byte(fr[i]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fr = '{8'h42, 8'h43, 8'h39};
    send_frame(fr);
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL midreset_idle: got state %0d want %0d", dut.state_q, ST_IDLE); end
    checks++; if (eq.size() !== 0) begin errors++; $display("FAIL midreset_no_err: got %0d pulses want 0", eq.size()); end
    checks++; if (xq.size() !== 0) begin errors++; $display("FAIL midreset_no_out: got %0d bytes want 0", xq.size()); end
  endtask

`ifdef XBEE_API_ESCAPE_EN
  task automatic test_escape();
    clr();
    fr = '{8'h7E, 8'h00, 8'h01, 8'h7D, 8'h5E, 8'h81};
    send_frame(fr);
    checks++; if (xq.size() !== 1) begin errors++; $display("FAIL esc_count: got %0d want 1", xq.size()); end
    checks++; if (xq.size() > 0 && xq[0] !== 9'h17E) begin errors++; $display("FAIL esc_byte: got %h want 17e", xq[0]); end
    checks++; if (eq.size() !== 0) begin errors++; $display("FAIL esc_no_err: got %0d pulses want 0", eq.size()); end
    clr();
    fr = '{8'h7E, 8'h00, 8'h05, 8'h7E, 8'h00, 8'h01, 8'h41, 8'hBE};
    send_frame(fr);
    checks++; if (xq.size() !== 1) begin errors++; $display("FAIL abort_count: got %0d want 1", xq.size()); end
    checks++; if (xq.size() > 0 && xq[0] !== 9'h141) begin errors++; $display("FAIL abort_byte: got %h want 141", xq[0]); end
    checks++; if (eq.size() !== 0) begin errors++; $display("FAIL abort_no_err: got %0d pulses want 0", eq.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_length();
    test_framing_and_glitch();
    test_backpressure_overrun();
    test_reset_midframe();
`ifdef XBEE_API_ESCAPE_EN
    test_escape();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
